// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for one updown_mod_counter channel.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             up_down;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             wrap;

    // Driver side: issues commands, observes count.
    modport master (
        output enable, up_down, clear, load, load_val,
        input  out, tc, wrap
    );

    // Counter side.
    modport slave (
        input  enable, up_down, clear, load, load_val,
        output out, tc, wrap
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter (range 0..MAX_VAL) with prescaler, synchronous
// clear/load, and wrap-or-saturate behaviour at the limits.
module updown_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0,
    parameter int PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_mod_counter_if.slave  bus
);
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX      = MAX_VAL[WIDTH-1:0];
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] step_val;
    logic             at_limit;
    logic [WIDTH-1:0] load_clamped;

    // Next count for a step in the current direction; limit values are
    // compared explicitly so a non-power-of-two MAX_VAL still wraps correctly.
    always_comb begin
        step_val = out_q;
        at_limit = 1'b0;
        if (bus.up_down) begin
            at_limit = (out_q == MAX);
            if (at_limit) step_val = SATURATE ? MAX : '0;
            else          step_val = out_q + 1'b1;
        end else begin
            at_limit = (out_q == '0);
            if (at_limit) step_val = SATURATE ? '0 : MAX;
            else          step_val = out_q - 1'b1;
        end
    end

    assign load_clamped = (bus.load_val > MAX) ? MAX : bus.load_val;

    // Command priority clear > load > enable; prescaler gates the step.
    always_comb begin
        out_d     = out_q;
        pre_cnt_d = pre_cnt_q;
        wrap_d    = 1'b0;
        if (bus.clear) begin
            out_d     = '0;
            pre_cnt_d = '0;
        end else if (bus.load) begin
            out_d     = load_clamped;
            pre_cnt_d = '0;
        end else if (bus.enable) begin
            if (pre_cnt_q == PRE_LAST) begin
                out_d     = step_val;
                pre_cnt_d = '0;
                wrap_d    = at_limit;
            end else begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            pre_cnt_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            out_q     <= out_d;
            pre_cnt_q <= pre_cnt_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.wrap = wrap_q;
    // Terminal count depends on the live direction, not a registered copy.
    assign bus.tc   = bus.up_down ? (out_q == MAX) : (out_q == '0);
endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three channels (wrap, saturate, prescale 3)
// share one stimulus stream and are checked against an arithmetic model.
module tb_updown_mod_counter;
    localparam int W  = 4;
    localparam int MV = 9;
    localparam int N  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         en, ud, clr, ld;
    logic [W-1:0] lv;

    updown_mod_counter_if #(.WIDTH(W)) ia ();
    updown_mod_counter_if #(.WIDTH(W)) ib ();
    updown_mod_counter_if #(.WIDTH(W)) ic ();

    assign ia.enable = en;  assign ia.up_down = ud;  assign ia.clear = clr;
    assign ia.load = ld;    assign ia.load_val = lv;
    assign ib.enable = en;  assign ib.up_down = ud;  assign ib.clear = clr;
    assign ib.load = ld;    assign ib.load_val = lv;
    assign ic.enable = en;  assign ic.up_down = ud;  assign ic.clear = clr;
    assign ic.load = ld;    assign ic.load_val = lv;

    updown_mod_counter #(.WIDTH(W), .MAX_VAL(MV), .SATURATE(1'b0), .PRESCALE(1))
        dut_a (.clk(clk), .reset(reset), .bus(ia));
    updown_mod_counter #(.WIDTH(W), .MAX_VAL(MV), .SATURATE(1'b1), .PRESCALE(1))
        dut_b (.clk(clk), .reset(reset), .bus(ib));
    updown_mod_counter #(.WIDTH(W), .MAX_VAL(MV), .SATURATE(1'b0), .PRESCALE(3))
        dut_c (.clk(clk), .reset(reset), .bus(ic));

    logic [W-1:0] d_out  [N];
    logic         d_tc   [N];
    logic         d_wrap [N];
    assign d_out[0] = ia.out;  assign d_tc[0] = ia.tc;  assign d_wrap[0] = ia.wrap;
    assign d_out[1] = ib.out;  assign d_tc[1] = ib.tc;  assign d_wrap[1] = ib.wrap;
    assign d_out[2] = ic.out;  assign d_tc[2] = ic.tc;  assign d_wrap[2] = ic.wrap;

    // Reference model: plain integers, one entry per channel.
    int sat_m [N] = '{0, 1, 0};
    int pre_m [N] = '{1, 1, 3};
    int m_out [N];
    int m_pre [N];
    int m_wrap[N];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_out[i] = 0; m_pre[i] = 0; m_wrap[i] = 0;
        end
    endtask

    // One clock edge of the model, using the inputs presented before the edge.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            m_wrap[i] = 0;
            if (clr) begin
                m_out[i] = 0; m_pre[i] = 0;
            end else if (ld) begin
                m_out[i] = (int'(lv) > MV) ? MV : int'(lv);
                m_pre[i] = 0;
            end else if (en) begin
                if (m_pre[i] + 1 < pre_m[i]) begin
                    m_pre[i]++;
                end else begin
                    m_pre[i] = 0;
                    if (ud) begin
                        if (m_out[i] == MV) begin
                            m_wrap[i] = 1;
                            m_out[i]  = sat_m[i] ? MV : 0;
                        end else m_out[i]++;
                    end else begin
                        if (m_out[i] == 0) begin
                            m_wrap[i] = 1;
                            m_out[i]  = sat_m[i] ? 0 : MV;
                        end else m_out[i]--;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.out%0d", tag, i),  32'(d_out[i]),  32'(m_out[i]));
            chk($sformatf("%s.wrap%0d", tag, i), 32'(d_wrap[i]), 32'(m_wrap[i]));
            chk($sformatf("%s.tc%0d", tag, i),   32'(d_tc[i]),
                32'((ud && m_out[i] == MV) || (!ud && m_out[i] == 0)));
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic e, input logic u, input logic c,
                         input logic l, input logic [W-1:0] v);
        en = e; ud = u; clr = c; ld = l; lv = v;
    endtask

    initial begin
        drive(0, 1, 0, 0, '0);
        reset = 1'b1;
        model_reset();
        #12;
        check_all("rst");
        @(negedge clk);
        reset = 1'b0;

        // Up-count with wrap at 9.
        drive(1, 1, 0, 0, '0);
        for (int k = 0; k < 12; k++) begin
            tick("up");
            chk("up.a_out", 32'(ia.out), 32'((k + 1) % 10));
            chk("up.a_wrap", 32'(ia.wrap), 32'(k == 9));
            chk("up.a_tc", 32'(ia.tc), 32'(k == 8));
        end

        // Down from 0 wraps to 9.
        drive(0, 0, 1, 0, '0); tick("dclr");
        drive(1, 0, 0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            tick("dn");
            chk("dn.a_out", 32'(ia.out), 32'(9 - k));
            chk("dn.a_wrap", 32'(ia.wrap), 32'(k == 0));
        end

        // Saturation on channel B.
        drive(0, 1, 0, 1, 4'd8); tick("sld");
        drive(1, 1, 0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            tick("sup");
            chk("sup.b_out", 32'(ib.out), 32'd9);
            chk("sup.b_wrap", 32'(ib.wrap), 32'(k != 0));
        end
        drive(0, 0, 1, 0, '0); tick("sclr");
        drive(1, 0, 0, 0, '0);
        for (int k = 0; k < 2; k++) begin
            tick("sdn");
            chk("sdn.b_out", 32'(ib.out), 32'd0);
            chk("sdn.b_tc", 32'(ib.tc), 32'd1);
            chk("sdn.b_wrap", 32'(ib.wrap), 32'd1);
        end

        // Load clamp and priorities.
        drive(0, 1, 0, 1, 4'd14); tick("ldc");
        chk("ldc.a_out", 32'(ia.out), 32'd9);
        drive(1, 1, 1, 1, 4'd5); tick("clrld");
        chk("clrld.a_out", 32'(ia.out), 32'd0);
        drive(1, 1, 0, 1, 4'd5); tick("lden");
        chk("lden.a_out", 32'(ia.out), 32'd5);
        chk("lden.c_out", 32'(ic.out), 32'd5);

        // Prescale 3 on channel C, with one enable gap.
        drive(0, 1, 1, 0, '0); tick("pclr");
        drive(1, 1, 0, 0, '0);
        tick("p1"); chk("p1.c", 32'(ic.out), 32'd0);
        tick("p2"); chk("p2.c", 32'(ic.out), 32'd0);
        tick("p3"); chk("p3.c", 32'(ic.out), 32'd1);
        tick("p4"); chk("p4.c", 32'(ic.out), 32'd1);
        drive(0, 1, 0, 0, '0);
        tick("p5"); chk("p5.c", 32'(ic.out), 32'd1);
        drive(1, 1, 0, 0, '0);
        tick("p6"); chk("p6.c", 32'(ic.out), 32'd1);
        tick("p7"); chk("p7.c", 32'(ic.out), 32'd2);

        // Async reset between edges, mid-prescale.
        tick("pre_r");
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst.a_out", 32'(ia.out), 32'd0);
        chk("arst.a_wrap", 32'(ia.wrap), 32'd0);
        chk("arst.c_out", 32'(ic.out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick("ar1"); chk("ar1.c", 32'(ic.out), 32'd0);
        tick("ar2"); chk("ar2.c", 32'(ic.out), 32'd0);
        tick("ar3"); chk("ar3.c", 32'(ic.out), 32'd1);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 99) < 75, $urandom_range(0, 1),
                  $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 8,
                  W'($urandom_range(0, 15)));
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
